// File: rtl/pipe_stage_chain.sv
// Instruction/PC pipeline register chain with its own fetch PC generator.
// Latency: one cycle per stage; retire is combinational from the oldest stage's state.
// Stall freezes pc and stages 1..STALL_STAGE and injects a bubble above them; a branch flush squashes younger stages and overrides stall.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   fetch_ir / pc         instruction fetched at pc (combinational memory read) / fetch address
//   stall                 hazard stall request
//   branch_taken/_target  branch resolved in stage BR_STAGE and its target address
//   stage_ir/pc/valid     packed per-stage contents, stage i in slice i-1
//   retire                valid instruction leaves the oldest stage this cycle
//   stall_count/flush_count  saturating event counters
module pipe_stage_chain #(
  parameter int          IR_W        = 8,
  parameter int          PC_W        = 8,
  parameter int          STAGES      = 4,
  parameter int          STALL_STAGE = 2,
  parameter int          BR_STAGE    = 4,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned NOP_IR      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [IR_W-1:0]          fetch_ir,
  output logic [PC_W-1:0]          pc,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [PC_W-1:0]          branch_target,
  output logic [STAGES*IR_W-1:0]   stage_ir,
  output logic [STAGES*PC_W-1:0]   stage_pc,
  output logic [STAGES-1:0]        stage_valid,
  output logic                     retire,
  output logic [15:0]              stall_count,
  output logic [15:0]              flush_count
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [IR_W-1:0] NOP    = IR_W'(NOP_IR);

  if (STAGES < 2 || STAGES > 8 || STALL_STAGE < 1 || STALL_STAGE >= BR_STAGE ||
      BR_STAGE > STAGES) begin : g_bad_params
    $error("pipe_stage_chain: illegal STAGES/STALL_STAGE/BR_STAGE combination");
  end

  logic flush;
  logic stl;

  // A taken branch only counts when the resolving stage holds a real instruction.
  assign flush = branch_taken & stage_valid[BR_STAGE-1];
  assign stl   = stall & ~flush;

  logic [STAGES-1:0][IR_W-1:0] ir_q;
  logic [STAGES-1:0][PC_W-1:0] spc_q;
  logic [STAGES-1:0]           vld_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RST_PC;
    end else if (flush) begin
      pc <= branch_target;
    end else if (!stl) begin
      pc <= pc + PC_W'(1);
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    // Stages below the branch stage hold wrong-path instructions on a flush.
    // The branch stage itself takes its predecessor normally, which gives
    // BR_STAGE-1 bubbles of penalty.
    localparam bit BUBBLE_ON_FLUSH = (k < BR_STAGE);
    localparam bit HOLD_ON_STALL   = (k <= STALL_STAGE);
    localparam bit BUBBLE_ON_STALL = (k == STALL_STAGE + 1);

    logic [IR_W-1:0] src_ir;
    logic [PC_W-1:0] src_pc;
    logic            src_vld;
    logic [IR_W-1:0] ir_r;
    logic [PC_W-1:0] pc_r;
    logic            vld_r;

    if (k == 1) begin : g_head
      assign src_ir  = fetch_ir;
      assign src_pc  = pc;
      assign src_vld = 1'b1;
    end else begin : g_body
      assign src_ir  = ir_q[k-2];
      assign src_pc  = spc_q[k-2];
      assign src_vld = vld_q[k-2];
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ir_r  <= NOP;
        pc_r  <= '0;
        vld_r <= 1'b0;
      end else if ((flush && BUBBLE_ON_FLUSH) || (stl && BUBBLE_ON_STALL)) begin
        ir_r  <= NOP;
        pc_r  <= '0;
        vld_r <= 1'b0;
      end else if (!(stl && HOLD_ON_STALL)) begin
        ir_r  <= src_ir;
        pc_r  <= src_pc;
        vld_r <= src_vld;
      end
    end

    assign ir_q[k-1]  = ir_r;
    assign spc_q[k-1] = pc_r;
    assign vld_q[k-1] = vld_r;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stl && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
      if (flush && flush_count != 16'hFFFF) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

  assign stage_ir    = ir_q;
  assign stage_pc    = spc_q;
  assign stage_valid = vld_q;
  // The oldest stage never holds, so its valid bit alone marks retirement.
  assign retire      = vld_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
`timescale 1ns/1ps
module tb_pipe_stage_chain;

  localparam int S  = 4;
  localparam int SS = 2;
  localparam int BR = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  fetch_ir;
  logic [7:0]  pc;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [31:0] stage_ir;
  logic [31:0] stage_pc;
  logic [3:0]  stage_valid;
  logic        retire;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  pipe_stage_chain #(
    .IR_W(8), .PC_W(8), .STAGES(S), .STALL_STAGE(SS), .BR_STAGE(BR),
    .RESET_PC(0), .NOP_IR(0)
  ) dut (
    .clock(clock), .reset(reset), .fetch_ir(fetch_ir), .pc(pc),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .stage_ir(stage_ir), .stage_pc(stage_pc), .stage_valid(stage_valid),
    .retire(retire), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  // Instruction memory: each word is its address plus 0x10.
  assign fetch_ir = pc + 8'h10;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ir;
    logic [31:0] spc;
    logic [3:0]  v;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  // Reference pipeline: one slot per stage, index 1 = youngest.
  logic [7:0] m_pc;
  logic [7:0] m_ir  [1:S];
  logic [7:0] m_spc [1:S];
  logic       m_v   [1:S];
  int         m_sc;
  int         m_fc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    for (int k = 1; k <= S; k++) begin
      m_ir[k] = 8'h00; m_spc[k] = 8'h00; m_v[k] = 1'b0;
    end
    m_sc = 0;
    m_fc = 0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic [7:0] tgt);
    logic       fl, sl;
    logic [7:0] n_ir  [1:S];
    logic [7:0] n_spc [1:S];
    logic       n_v   [1:S];
    exp_t       e;
    fl = br && m_v[BR];
    sl = st && !fl;
    for (int k = 1; k <= S; k++) begin
      if ((fl && k < BR) || (sl && k == SS + 1)) begin
        n_ir[k] = 8'h00; n_spc[k] = 8'h00; n_v[k] = 1'b0;
      end else if (sl && k <= SS) begin
        n_ir[k] = m_ir[k]; n_spc[k] = m_spc[k]; n_v[k] = m_v[k];
      end else if (k == 1) begin
        n_ir[k] = m_pc + 8'h10; n_spc[k] = m_pc; n_v[k] = 1'b1;
      end else begin
        n_ir[k] = m_ir[k-1]; n_spc[k] = m_spc[k-1]; n_v[k] = m_v[k-1];
      end
    end
    for (int k = 1; k <= S; k++) begin
      m_ir[k] = n_ir[k]; m_spc[k] = n_spc[k]; m_v[k] = n_v[k];
    end
    if (fl)       m_pc = tgt;
    else if (!sl) m_pc = m_pc + 8'h01;
    if (sl && m_sc < 65535) m_sc++;
    if (fl && m_fc < 65535) m_fc++;
    e.pc = m_pc;
    for (int k = 1; k <= S; k++) begin
      e.ir[(k-1)*8 +: 8]  = m_ir[k];
      e.spc[(k-1)*8 +: 8] = m_spc[k];
      e.v[k-1]            = m_v[k];
    end
    e.sc = 16'(m_sc);
    e.fc = 16'(m_fc);
    sbq.push_back(e);
  endtask

  // Drive one cycle of stimulus, record its expected outcome, and return
  // 2 time units after the edge.
  task automatic step(input logic st, input logic br, input logic [7:0] tgt);
    @(negedge clock);
    stall = st; branch_taken = br; branch_target = tgt;
    model_step(st, br, tgt);
    @(posedge clock);
    #2;
  endtask

  // Monitor: every edge that has an expected entry pending is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_pc",     pc,          e.pc);
        chk("sb_ir",     stage_ir,    e.ir);
        chk("sb_spc",    stage_pc,    e.spc);
        chk("sb_valid",  stage_valid, e.v);
        chk("sb_retire", retire,      e.v[S-1]);
        chk("sb_stalls", stall_count, e.sc);
        chk("sb_flushes", flush_count, e.fc);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    chk("rst_pc", pc, 8'h00);
    chk("rst_valid", stage_valid, 4'h0);
    chk("rst_ir", stage_ir, 32'h0);
    chk("rst_cnt", {stall_count, flush_count}, 32'h0);
    reset = 1'b0;

    // Fill the pipe.
    repeat (4) step(1'b0, 1'b0, 8'h00);
    chk("fill_valid", stage_valid, 4'hF);
    chk("fill_s1", {stage_ir[7:0], stage_pc[7:0]}, 16'h1303);
    chk("fill_s4", {stage_ir[31:24], stage_pc[31:24]}, 16'h1000);
    chk("fill_pc", pc, 8'h04);
    chk("fill_retire", retire, 1'b1);

    // Single-cycle stall.
    step(1'b1, 1'b0, 8'h00);
    chk("stall_pc", pc, 8'h04);
    chk("stall_s12", stage_ir[15:0], 16'h1213);
    chk("stall_s3", {stage_ir[23:16], 7'd0, stage_valid[2]}, 16'h0000);
    chk("stall_s4", stage_ir[31:24], 8'h11);
    chk("stall_cnt", stall_count, 16'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("stall_resume", stage_ir[7:0], 8'h14);

    // Branch flush with stage 4 valid.
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h40);
    chk("flush_pc", pc, 8'h40);
    chk("flush_valid", stage_valid[2:0], 3'b000);
    chk("flush_cnt", flush_count, 16'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("flush_target", {stage_ir[7:0], stage_pc[7:0]}, 16'h5040);
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // Stall and branch together: flush wins.
    step(1'b1, 1'b1, 8'h80);
    chk("both_pc", pc, 8'h80);
    chk("both_valid", stage_valid[2:0], 3'b000);
    chk("both_stalls", stall_count, 16'd1);
    chk("both_flushes", flush_count, 16'd2);

    // Branch against an invalid stage 4 is ignored.
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h33);
    chk("ign_pc", pc, 8'h82);
    chk("ign_flushes", flush_count, 16'd2);

    // PC wrap 0xFF -> 0x00.
    for (int i = 0; i < 8 && !m_v[BR]; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFE);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_s1", {stage_ir[7:0], stage_pc[7:0]}, 16'h0FFF);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom % 10) < 3, ($urandom % 10) < 2, 8'($urandom));

    // Asynchronous reset between edges.
    #1;
    reset = 1'b1;
    #1;
    chk("arst_pc", pc, 8'h00);
    chk("arst_valid", stage_valid, 4'h0);
    chk("arst_cnt", {stall_count, flush_count}, 32'h0);
    chk("arst_retire", retire, 1'b0);
    model_reset();
    stall = 1'b0; branch_taken = 1'b0;
    reset = 1'b0;

    // Stall counter saturation.
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b0, 8'h00);
    chk("sat_stalls", stall_count, 16'hFFFF);
    for (int i = 0; i < 50; i++)
      step(($urandom % 10) < 3, ($urandom % 10) < 2, 8'($urandom));

    @(posedge clock);
    #2;
    chk("sb_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised instruction/PC pipeline register chain with its own fetch PC generator.
- Replaces the fixed chain of IR1..IR4 registers, PC2..PC4 registers and the PC+1 / branch-target selection in the pipelined processor top level.
- Adds things the fixed chain lacks: per-stage valid bits, stall with bubble insertion, branch flush of younger stages, and saturating stall/flush event counters for the HEX display.

Parameters:
IR_W, 8, instruction width
PC_W, 8, program-counter width
STAGES, 4, number of pipeline stages (2..8); stage 1 = fetch IR, stage STAGES = oldest
STALL_STAGE, 2, highest stage frozen by a stall (1..STAGES-1)
BR_STAGE, 4, stage whose instruction resolves branches (STALL_STAGE+1..STAGES)
RESET_PC, 0, PC value after reset
NOP_IR, 0, IR value loaded into a bubble

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
fetch_ir  in  IR_W  instruction read combinationally from memory at pc
pc  out  PC_W  fetch address
stall  in  1  hazard stall request from decode/RF control
branch_taken  in  1  branch in stage BR_STAGE resolved taken
branch_target  in  PC_W  target address, valid with branch_taken
stage_ir  out  STAGES*IR_W  stage i at bits [i*IR_W-1:(i-1)*IR_W]
stage_pc  out  STAGES*PC_W  PC of instruction in stage i, same packing
stage_valid  out  STAGES  bit i-1 = stage i holds a real instruction
retire  out  1  valid instruction leaves stage STAGES this cycle (combinational)
stall_count  out  16  saturating count of stall cycles
flush_count  out  16  saturating count of flush events

Behaviour:
- Reset (asynchronous, takes effect with no clock edge):
  - pc = RESET_PC.
  - All stage_ir = NOP_IR, stage_pc = 0, stage_valid = 0.
  - Both counters = 0.
- Effective flush: flush = branch_taken & stage_valid[BR_STAGE-1]. branch_taken is ignored when the BR stage is invalid.
- Effective stall: stl = stall & ~flush. Flush always overrides stall.
- Normal advance (no stl, no flush):
  - Stage 1 <= {fetch_ir, pc, valid=1}.
  - Stage k <= stage k-1 for k = 2..STAGES.
  - pc <= pc+1, wrapping modulo 2^PC_W (0xFF+1 = 0x00).
- Stall (stl):
  - pc and stages 1..STALL_STAGE hold.
  - Stage STALL_STAGE+1 <= bubble {NOP_IR, pc 0, valid 0}.
  - Stages above STALL_STAGE+1 advance normally.
  - stall_count +1, saturating at 0xFFFF.
- Flush (flush):
  - Stages 1..BR_STAGE-1 <= bubble.
  - Stages BR_STAGE+1..STAGES advance normally.
  - pc <= branch_target. The instruction at the target enters stage 1 one cycle later, so branch penalty = BR_STAGE-1 bubbles.
  - flush_count +1 per flush event (not per squashed instruction), saturating at 0xFFFF.
- Stall held for N consecutive cycles: stall_count +N; only one new bubble is injected per cycle.
- retire = stage_valid[STAGES-1] & (the stage is not holding). Stage STAGES never holds, so retire = stage_valid[STAGES-1].
- Bubbles propagate like instructions but keep valid = 0. Downstream controllers must gate all writes (RFWrite, MemWrite, FlagWrite, branch) with the stage valid bit.
- Illegal parameter combinations (STALL_STAGE >= BR_STAGE, STAGES < 2) must fail elaboration.
- The block has no combinational path from stall or branch_taken to any registered output; only retire is combinational, from state.

Test Plan (defaults; memory model returns fetch_ir = pc+0x10):
1. Release reset, 4 edges, no stall/branch -> stage_valid=4'b1111; stage1 ir 0x13 pc 0x03; stage4 ir 0x10 pc 0x00; pc=0x04; retire=1.
2. Steady state (pc=0x04), stall high 1 cycle -> pc stays 0x04; stage1/2 hold 0x13/0x12; stage3 ir 0x00 valid 0; stage4 ir 0x11; stall_count=1. Next cycle stage1=0x14.
3. Stage4 valid, branch_taken=1, target 0x40 -> pc=0x40; stages1-3 valid 0; flush_count=1. Next edge stage1 ir 0x50 pc 0x40. Three invalid cycles appear at stage4.
4. stall=1 and branch_taken=1 in the same cycle with stage4 valid -> flush behaviour exactly as scenario 3; stall_count unchanged.
5. branch_taken=1 while stage4 invalid (bubble) -> ignored: normal advance, flush_count unchanged. Also: pc=0xFF advance -> 0x00.
6. Assert reset mid-run between clock edges -> pc=0x00, stage_valid=0, counters 0 immediately. Also: stall held for 70000 cycles -> stall_count saturates at 0xFFFF.
